// File: rtl/vision_pkg.sv
// Shared definitions for the camera vision path: address width, pooling modes
// and the RGB565 green-channel boost used for ink classification.
package vision_pkg;

   localparam int unsigned ADDR_W      = 10;
   localparam int unsigned MODE_BINARY = 0;
   localparam int unsigned MODE_MULTI  = 1;

   // Doubles the 6-bit green channel and clips to 63, at 7-bit width.
   function automatic logic [6:0] green_boost(input logic [15:0] rgb);
      logic [6:0] w_b;
      w_b = {rgb[10:5], 1'b0};
      return (w_b > 7'd63) ? 7'd63 : w_b;
   endfunction

endpackage

// File: rtl/cell_line_accum.sv
// Line buffer of per-column-cell ink counters; accumulates across the CELL rows
// of a cell row and hands back the final count on the closing pixel.
module cell_line_accum
   import vision_pkg::*;
#(
   parameter int unsigned GRID  = 28,
   parameter int unsigned CNT_W = 5,
   parameter int unsigned IDX_W = 5
) (
   input  logic             dclk,
   input  logic             clr,
   input  logic             add_en,
   input  logic [IDX_W-1:0] idx,
   input  logic             ink,
   input  logic             close,
   output logic [CNT_W-1:0] count_out
);

   logic [CNT_W-1:0] r_cnt [GRID];

   // Includes the current pixel so the closing count is complete.
   assign count_out = r_cnt[idx] + CNT_W'(ink);

   always_ff @(posedge dclk) begin
      if (clr) begin
         for (int i = 0; i < int'(GRID); i++) begin
            r_cnt[i] <= '0;
         end
      end else if (add_en) begin
         r_cnt[idx] <= close ? '0 : count_out;
      end
   end

endmodule

// File: rtl/roi_grid_pooler.sv
// Downsamples a square camera ROI into GRID x GRID cells by counting ink pixels per
// cell, writing one value per cell and a per-frame nonzero-cell summary.
module roi_grid_pooler
   import vision_pkg::*;
#(
   parameter int unsigned X_START    = 104,
   parameter int unsigned Y_START    = 64,
   parameter int unsigned GRID       = 28,
   parameter int unsigned CELL_LOG2  = 2,
   parameter int unsigned INK_THRESH = 50,
   parameter int unsigned MODE       = 0,
   parameter int unsigned VOTE       = 8,
   parameter int unsigned DATA_W     = 1
) (
   input  logic              dclk,
   input  logic              rst_n,
   input  logic              vsync,
   input  logic              href,
   input  logic              pixel_valid,
   input  logic [15:0]       pixel_rgb,
   output logic [ADDR_W-1:0] grid_addr,
   output logic [DATA_W-1:0] grid_data,
   output logic              grid_wr_en,
   output logic              frame_done,
   output logic [ADDR_W-1:0] frame_ink,
   output logic              in_roi
);

   localparam int unsigned CELL  = 1 << CELL_LOG2;
   localparam int unsigned ROI_W = GRID * CELL;
   localparam int unsigned CW    = 11;
   localparam int unsigned CNT_W = 2 * CELL_LOG2 + 1;
   localparam int unsigned IDX_W = (GRID > 1) ? $clog2(GRID) : 1;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(GRID * GRID - 1);
   localparam logic [DATA_W-1:0] DATA_MAX  = '1;

   logic [CW-1:0]     r_cam_x;
   logic [CW-1:0]     r_cam_y;
   logic              r_href_q;
   logic              r_wr_en;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_data;
   logic              r_frame_done;
   logic [ADDR_W-1:0] r_frame_ink;
   logic [ADDR_W-1:0] r_nz_cnt;

   logic [CW-1:0]     w_dx;
   logic [CW-1:0]     w_dy;
   logic              w_in_roi;
   logic              w_accept;
   logic              w_close;
   logic              w_ink;
   logic              w_clr;
   logic [IDX_W-1:0]  w_gx;
   logic [IDX_W-1:0]  w_gy;
   logic [CNT_W-1:0]  w_count;
   logic [31:0]       w_count32;
   logic [DATA_W-1:0] w_data;
   logic [ADDR_W-1:0] w_addr;
   logic              w_nz_inc;
   logic              w_unused_rgb;

   // Offsets wrap when left of / above the ROI; the explicit >= tests reject those.
   assign w_dx     = r_cam_x - CW'(X_START);
   assign w_dy     = r_cam_y - CW'(Y_START);
   assign w_in_roi = (r_cam_x >= CW'(X_START)) && (w_dx < CW'(ROI_W)) &&
                     (r_cam_y >= CW'(Y_START)) && (w_dy < CW'(ROI_W));
   assign w_accept = vsync && href && pixel_valid && w_in_roi;
   assign w_close  = (&w_dx[CELL_LOG2-1:0]) && (&w_dy[CELL_LOG2-1:0]);
   assign w_gx     = IDX_W'(w_dx >> CELL_LOG2);
   assign w_gy     = IDX_W'(w_dy >> CELL_LOG2);
   assign w_addr   = ADDR_W'(32'(w_gy) * GRID + 32'(w_gx));
   assign w_ink    = (32'(green_boost(pixel_rgb)) < INK_THRESH);
   assign w_clr    = !rst_n || !vsync;
   assign w_nz_inc = |r_data;
   assign w_unused_rgb = ^{pixel_rgb[15:11], pixel_rgb[4:0]};

   cell_line_accum #(
      .GRID  (GRID),
      .CNT_W (CNT_W),
      .IDX_W (IDX_W)
   ) u_accum (
      .dclk      (dclk),
      .clr       (w_clr),
      .add_en    (w_accept),
      .idx       (w_gx),
      .ink       (w_ink),
      .close     (w_close),
      .count_out (w_count)
   );

   always_comb begin
      w_count32 = 32'(w_count);
      if (MODE == MODE_BINARY) begin
         w_data = DATA_W'(w_count32 >= VOTE);
      end else begin
         w_data = (w_count32 > 32'(DATA_MAX)) ? DATA_MAX : w_count32[DATA_W-1:0];
      end
   end

   always_ff @(posedge dclk) begin
      if (!rst_n || !vsync) begin
         r_cam_x  <= '0;
         r_cam_y  <= '0;
         r_href_q <= 1'b0;
      end else begin
         r_href_q <= href;
         if (r_href_q && !href) begin
            r_cam_x <= '0;
            r_cam_y <= r_cam_y + CW'(1);
         end else if (href && pixel_valid) begin
            r_cam_x <= r_cam_x + CW'(1);
         end
      end
   end

   // The nonzero-cell count is taken from the registered write, so frame_done
   // lands one cycle after the final write strobe.
   always_ff @(posedge dclk) begin
      if (!rst_n) begin
         r_wr_en      <= 1'b0;
         r_addr       <= '0;
         r_data       <= '0;
         r_frame_done <= 1'b0;
         r_frame_ink  <= '0;
         r_nz_cnt     <= '0;
      end else if (!vsync) begin
         r_wr_en      <= 1'b0;
         r_frame_done <= 1'b0;
         r_nz_cnt     <= '0;
      end else begin
         r_wr_en      <= w_accept && w_close;
         r_frame_done <= 1'b0;
         if (w_accept && w_close) begin
            r_addr <= w_addr;
            r_data <= w_data;
         end
         if (r_wr_en) begin
            if (r_addr == LAST_ADDR) begin
               r_frame_ink  <= r_nz_cnt + ADDR_W'(w_nz_inc);
               r_frame_done <= 1'b1;
               r_nz_cnt     <= '0;
            end else begin
               r_nz_cnt <= r_nz_cnt + ADDR_W'(w_nz_inc);
            end
         end
      end
   end

   assign grid_wr_en = r_wr_en;
   assign grid_addr  = r_addr;
   assign grid_data  = r_data;
   assign frame_done = r_frame_done;
   assign frame_ink  = r_frame_ink;
   assign in_roi     = w_in_roi;

endmodule
